// File: rtl/input_conditioner.sv
// Debounces the synchronized fork/crank sensors and Mode/Trip buttons and turns
// them into single-cycle event pulses for the cycle-computer core.
module input_conditioner #(
  parameter int unsigned SENSOR_DEBOUNCE   = 8,
  parameter int unsigned BUTTON_DEBOUNCE   = 256,
  parameter int unsigned LONG_PRESS_CYCLES = 32768
) (
  input  logic Clock,
  input  logic nReset,
  input  logic nFork,
  input  logic nCrank,
  input  logic nMode,
  input  logic nTrip,
  output logic ForkPulse,
  output logic CrankPulse,
  output logic ModePress,
  output logic TripPress,
  output logic ModeLong,
  output logic TripLong,
  output logic BothLong
);

  localparam int unsigned SW = $clog2(SENSOR_DEBOUNCE);
  localparam int unsigned BW = $clog2(BUTTON_DEBOUNCE);
  localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [SW-1:0] SENS_LAST = SW'(SENSOR_DEBOUNCE - 1);
  localparam logic [BW-1:0] BTN_LAST  = BW'(BUTTON_DEBOUNCE - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_DUE  = HW'(LONG_PRESS_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE,
    MODE_DN,
    TRIP_DN,
    BOTH_DN,
    LOCKOUT
  } btnStateT;

  logic [1:0]         sensRaw, sensLvl, sensPrev;
  logic [1:0][SW-1:0] sensCnt;
  logic [1:0]         btnRaw, btnLvl;
  logic [1:0][BW-1:0] btnCnt;

  btnStateT        state, stateNext;
  logic [HW-1:0]   hold;
  logic            m, t, longDue;
  logic            modePressNext, tripPressNext, modeLongNext, tripLongNext, bothLongNext;

  always_comb begin
    sensRaw = {nCrank, nFork};
    btnRaw  = {nTrip, nMode};
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sensLvl <= '1;
      sensCnt <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sensRaw[i] == sensLvl[i]) begin
          sensCnt[i] <= '0;
        end else if (sensCnt[i] == SENS_LAST) begin
          sensLvl[i] <= sensRaw[i];
          sensCnt[i] <= '0;
        end else begin
          sensCnt[i] <= sensCnt[i] + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      btnLvl <= '1;
      btnCnt <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (btnRaw[i] == btnLvl[i]) begin
          btnCnt[i] <= '0;
        end else if (btnCnt[i] == BTN_LAST) begin
          btnLvl[i] <= btnRaw[i];
          btnCnt[i] <= '0;
        end else begin
          btnCnt[i] <= btnCnt[i] + BW'(1);
        end
      end
    end
  end

  // Sensor pulse fires the cycle after the debounced level falls.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sensPrev   <= '1;
      ForkPulse  <= 1'b0;
      CrankPulse <= 1'b0;
    end else begin
      sensPrev   <= sensLvl;
      ForkPulse  <= sensPrev[0] & ~sensLvl[0];
      CrankPulse <= sensPrev[1] & ~sensLvl[1];
    end
  end

  always_comb begin
    m = ~btnLvl[0];
    t = ~btnLvl[1];
    // Decided one edge early so the registered pulse lands as H reaches the limit.
    longDue = (hold == HOLD_DUE);
  end

  always_comb begin
    stateNext     = state;
    modePressNext = 1'b0;
    tripPressNext = 1'b0;
    modeLongNext  = 1'b0;
    tripLongNext  = 1'b0;
    bothLongNext  = 1'b0;
    case (state)
      IDLE: begin
        if (m && t)  stateNext = BOTH_DN;
        else if (m)  stateNext = MODE_DN;
        else if (t)  stateNext = TRIP_DN;
      end
      MODE_DN: begin
        if (!m) begin
          modePressNext = 1'b1;
          stateNext     = IDLE;
        end else if (t) begin
          stateNext = BOTH_DN;
        end else if (longDue) begin
          modeLongNext = 1'b1;
          stateNext    = LOCKOUT;
        end
      end
      TRIP_DN: begin
        if (!t) begin
          tripPressNext = 1'b1;
          stateNext     = IDLE;
        end else if (m) begin
          stateNext = BOTH_DN;
        end else if (longDue) begin
          tripLongNext = 1'b1;
          stateNext    = LOCKOUT;
        end
      end
      BOTH_DN: begin
        if (!m || !t) begin
          stateNext = LOCKOUT;
        end else if (longDue) begin
          bothLongNext = 1'b1;
          stateNext    = LOCKOUT;
        end
      end
      LOCKOUT: begin
        if (!m && !t) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      hold      <= '0;
      ModePress <= 1'b0;
      TripPress <= 1'b0;
      ModeLong  <= 1'b0;
      TripLong  <= 1'b0;
      BothLong  <= 1'b0;
    end else begin
      state <= stateNext;
      if (stateNext != state)  hold <= '0;
      else if (hold != HOLD_MAX) hold <= hold + HW'(1);
      ModePress <= modePressNext;
      TripPress <= tripPressNext;
      ModeLong  <= modeLongNext;
      TripLong  <= tripLongNext;
      BothLong  <= bothLongNext;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus randomized
// input traffic, checked every cycle against a timestamp-based reference model.
module tb_input_conditioner;

  localparam int SD = 4;
  localparam int BD = 8;
  localparam int LP = 32;

  logic Clock = 1'b0;
  logic nReset = 1'b0;
  logic nFork = 1'b1, nCrank = 1'b1, nMode = 1'b1, nTrip = 1'b1;
  logic ForkPulse, CrankPulse, ModePress, TripPress, ModeLong, TripLong, BothLong;

  int tests = 0;
  int fails = 0;

  always #5 Clock = ~Clock;

  input_conditioner #(
    .SENSOR_DEBOUNCE(SD),
    .BUTTON_DEBOUNCE(BD),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .Clock(Clock), .nReset(nReset),
    .nFork(nFork), .nCrank(nCrank), .nMode(nMode), .nTrip(nTrip),
    .ForkPulse(ForkPulse), .CrankPulse(CrankPulse),
    .ModePress(ModePress), .TripPress(TripPress),
    .ModeLong(ModeLong), .TripLong(TripLong), .BothLong(BothLong)
  );

  // {ForkPulse, CrankPulse, ModePress, TripPress, ModeLong, TripLong, BothLong}
  logic [6:0] outVec;
  logic [6:0] expVec;
  assign outVec = {ForkPulse, CrankPulse, ModePress, TripPress, ModeLong, TripLong, BothLong};

  // Reference model: a level is accepted once a run of identical raw samples of
  // length N disagrees with it; button sessions are tracked by start timestamp.
  bit          mLvl [4];
  bit          mLast[4];
  int          mRun [4];
  bit          mPrev[2];
  int          mOwner;   // 0 none, 1 mode, 2 trip, 3 both, 4 waiting for full release
  int          mSince;
  int          mCyc;

  always @(posedge Clock or negedge nReset) begin
    bit         raw[4];
    bit         m, t;
    logic [6:0] e;
    if (!nReset) begin
      for (int i = 0; i < 4; i++) begin
        mLvl[i] = 1'b1; mLast[i] = 1'b1; mRun[i] = 0;
      end
      mPrev[0] = 1'b1; mPrev[1] = 1'b1;
      mOwner = 0; mSince = 0; mCyc = 0;
      expVec = '0;
    end else begin
      mCyc++;
      raw[0] = nFork; raw[1] = nCrank; raw[2] = nMode; raw[3] = nTrip;
      e = '0;
      e[6] = mPrev[0] & ~mLvl[0];
      e[5] = mPrev[1] & ~mLvl[1];
      mPrev[0] = mLvl[0];
      mPrev[1] = mLvl[1];
      m = !mLvl[2];
      t = !mLvl[3];
      case (mOwner)
        0: begin
          if (m && t)  begin mOwner = 3; mSince = mCyc; end
          else if (m)  begin mOwner = 1; mSince = mCyc; end
          else if (t)  begin mOwner = 2; mSince = mCyc; end
        end
        1: begin
          if (!m)                          begin e[4] = 1'b1; mOwner = 0; end
          else if (t)                      begin mOwner = 3; mSince = mCyc; end
          else if (mCyc - mSince == LP - 1) begin e[2] = 1'b1; mOwner = 4; end
        end
        2: begin
          if (!t)                          begin e[3] = 1'b1; mOwner = 0; end
          else if (m)                      begin mOwner = 3; mSince = mCyc; end
          else if (mCyc - mSince == LP - 1) begin e[1] = 1'b1; mOwner = 4; end
        end
        3: begin
          if (!m || !t)                    mOwner = 4;
          else if (mCyc - mSince == LP - 1) begin e[0] = 1'b1; mOwner = 4; end
        end
        default: if (!m && !t) mOwner = 0;
      endcase
      for (int i = 0; i < 4; i++) begin
        if (raw[i] == mLast[i]) mRun[i]++;
        else mRun[i] = 1;
        mLast[i] = raw[i];
        if (raw[i] != mLvl[i] && mRun[i] >= ((i < 2) ? SD : BD)) mLvl[i] = raw[i];
      end
      expVec = e;
    end
  end

  task automatic test_reset();
    nReset = 1'b0;
    {nFork, nCrank, nMode, nTrip} = 4'b1111;
    for (int j = 0; j < 3; j++) begin
      @(negedge Clock);
      tests++;
      if (outVec !== 7'b0) begin
        fails++;
        $display("FAIL reset_outputs: got %b expected %b", outVec, 7'b0);
      end
    end
    nReset = 1'b1;
  endtask

  task automatic test_sensor_edge();
    int pulses, at;
    pulses = 0;
    for (int j = 1; j <= 13; j++) begin
      nFork = (j <= 3) ? 1'b0 : 1'b1;
      @(negedge Clock);
      tests++;
      if (outVec !== expVec) begin
        fails++;
        $display("FAIL sensor_glitch_cycle: got %b expected %b", outVec, expVec);
      end
      pulses += int'(ForkPulse);
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL sensor_glitch_count: got %0d pulses expected 0", pulses);
    end
    pulses = 0; at = 0;
    for (int j = 1; j <= 10; j++) begin
      nFork = 1'b0;
      @(negedge Clock);
      tests++;
      if (outVec !== expVec) begin
        fails++;
        $display("FAIL sensor_fall_cycle: got %b expected %b", outVec, expVec);
      end
      if (ForkPulse === 1'b1) begin
        pulses++;
        if (at == 0) at = j;
      end
    end
    tests++;
    if (pulses != 1 || at != SD + 1) begin
      fails++;
      $display("FAIL sensor_fall_pulse: got %0d pulses at edge %0d expected 1 at edge %0d", pulses, at, SD + 1);
    end
    pulses = 0;
    for (int j = 1; j <= 12; j++) begin
      nFork = 1'b1;
      @(negedge Clock);
      tests++;
      if (outVec !== expVec) begin
        fails++;
        $display("FAIL sensor_rise_cycle: got %b expected %b", outVec, expVec);
      end
      pulses += int'(ForkPulse);
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL sensor_rise_count: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_short_press();
    int presses, longs, at;
    presses = 0; longs = 0; at = 0;
    for (int j = 1; j <= 40; j++) begin
      nMode = (j <= 20) ? 1'b0 : 1'b1;
      @(negedge Clock);
      tests++;
      if (outVec !== expVec) begin
        fails++;
        $display("FAIL short_press_cycle: got %b expected %b", outVec, expVec);
      end
      if (ModePress === 1'b1) begin
        presses++;
        if (at == 0) at = j - 20;
      end
      longs += int'(ModeLong);
    end
    tests++;
    if (presses != 1 || at != BD + 1 || longs != 0) begin
      fails++;
      $display("FAIL short_press: got %0d presses at edge %0d, %0d longs expected 1 at edge %0d, 0 longs",
               presses, at, longs, BD + 1);
    end
  endtask

  task automatic test_long_press();
    int longs, shorts, at;
    longs = 0; shorts = 0; at = 0;
    for (int j = 1; j <= 85; j++) begin
      nTrip = (j <= 60) ? 1'b0 : 1'b1;
      @(negedge Clock);
      tests++;
      if (outVec !== expVec) begin
        fails++;
        $display("FAIL long_press_cycle: got %b expected %b", outVec, expVec);
      end
      if (TripLong === 1'b1) begin
        longs++;
        if (at == 0) at = j;
      end
      shorts += int'(TripPress);
    end
    tests++;
    if (longs != 1 || at != 1 + BD + LP - 1 || shorts != 0) begin
      fails++;
      $display("FAIL long_press: got %0d longs at edge %0d, %0d shorts expected 1 at edge %0d, 0 shorts",
               longs, at, shorts, 1 + BD + LP - 1);
    end
  endtask

  task automatic test_both_long();
    int both, others, at, modeFirst;
    both = 0; others = 0; at = 0;
    modeFirst = int'($urandom_range(0, 1));
    for (int j = 1; j <= 110; j++) begin
      nMode = (j <= 65 || (modeFirst == 0 && j <= 85)) ? 1'b0 : 1'b1;
      nTrip = (j < 6) ? 1'b1 : ((j <= 65 || (modeFirst == 1 && j <= 85)) ? 1'b0 : 1'b1);
      @(negedge Clock);
      tests++;
      if (outVec !== expVec) begin
        fails++;
        $display("FAIL both_long_cycle: got %b expected %b", outVec, expVec);
      end
      if (BothLong === 1'b1) begin
        both++;
        if (at == 0) at = j;
      end
      others += int'(ModePress) + int'(TripPress) + int'(ModeLong) + int'(TripLong);
    end
    tests++;
    if (both != 1 || at != 6 + BD + LP - 1 || others != 0) begin
      fails++;
      $display("FAIL both_long: got %0d BothLong at edge %0d, %0d other pulses expected 1 at edge %0d, 0 others",
               both, at, others, 6 + BD + LP - 1);
    end
  endtask

  task automatic test_both_abort();
    int pulses, presses;
    pulses = 0; presses = 0;
    for (int j = 1; j <= 45; j++) begin
      nMode = (j <= 15) ? 1'b0 : 1'b1;
      nTrip = (j <= 20) ? 1'b0 : 1'b1;
      @(negedge Clock);
      tests++;
      if (outVec !== expVec) begin
        fails++;
        $display("FAIL both_abort_cycle: got %b expected %b", outVec, expVec);
      end
      pulses += int'(ModePress) + int'(TripPress) + int'(ModeLong) + int'(TripLong) + int'(BothLong);
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL both_abort_count: got %0d button pulses expected 0", pulses);
    end
    for (int j = 1; j <= 30; j++) begin
      nMode = (j <= 12) ? 1'b0 : 1'b1;
      @(negedge Clock);
      tests++;
      if (outVec !== expVec) begin
        fails++;
        $display("FAIL idle_after_abort_cycle: got %b expected %b", outVec, expVec);
      end
      presses += int'(ModePress);
    end
    tests++;
    if (presses != 1) begin
      fails++;
      $display("FAIL idle_after_abort: got %0d ModePress expected 1", presses);
    end
  endtask

  task automatic test_crank_and_reset();
    int cranks, longs, at;
    cranks = 0; longs = 0;
    for (int j = 1; j <= 80; j++) begin
      nMode  = (j <= 60) ? 1'b0 : 1'b1;
      nCrank = (j >= 10 && j < 20) ? 1'b0 : 1'b1;
      @(negedge Clock);
      tests++;
      if (outVec !== expVec) begin
        fails++;
        $display("FAIL crank_during_hold_cycle: got %b expected %b", outVec, expVec);
      end
      cranks += int'(CrankPulse);
      longs  += int'(ModeLong);
    end
    tests++;
    if (cranks != 1 || longs != 1) begin
      fails++;
      $display("FAIL crank_during_hold: got %0d CrankPulse, %0d ModeLong expected 1, 1", cranks, longs);
    end
    nMode = 1'b0;
    for (int j = 1; j <= BD + 1 + 20; j++) begin
      @(negedge Clock);
    end
    nReset = 1'b0;
    @(negedge Clock);
    tests++;
    if (outVec !== 7'b0) begin
      fails++;
      $display("FAIL midhold_reset_outputs: got %b expected %b", outVec, 7'b0);
    end
    nReset = 1'b1;
    longs = 0; at = 0;
    for (int j = 1; j <= 50; j++) begin
      @(negedge Clock);
      tests++;
      if (outVec !== expVec) begin
        fails++;
        $display("FAIL after_reset_cycle: got %b expected %b", outVec, expVec);
      end
      if (ModeLong === 1'b1) begin
        longs++;
        if (at == 0) at = j;
      end
    end
    tests++;
    if (longs != 1 || at != 1 + BD + LP - 1) begin
      fails++;
      $display("FAIL after_reset_long: got %0d ModeLong at edge %0d expected 1 at edge %0d",
               longs, at, 1 + BD + LP - 1);
    end
    nMode = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge Clock);
      tests++;
      if (outVec !== expVec) begin
        fails++;
        $display("FAIL after_reset_release: got %b expected %b", outVec, expVec);
      end
    end
  endtask

  task automatic test_random();
    int         remain[4];
    logic [3:0] lv;
    lv = 4'b1111;
    for (int i = 0; i < 4; i++) remain[i] = 0;
    for (int j = 0; j < 3000; j++) begin
      for (int i = 0; i < 4; i++) begin
        if (remain[i] == 0) begin
          lv[i] = ~lv[i];
          if (i < 2)                          remain[i] = int'($urandom_range(1, 10));
          else if ($urandom_range(0, 3) == 0) remain[i] = int'($urandom_range(25, 45));
          else                                remain[i] = int'($urandom_range(1, 14));
        end
        remain[i]--;
      end
      {nTrip, nMode, nCrank, nFork} = lv;
      nReset = ($urandom_range(0, 599) != 0);
      @(negedge Clock);
      tests++;
      if (outVec !== expVec) begin
        fails++;
        $display("FAIL random_cycle_%0d: got %b expected %b", j, outVec, expVec);
      end
    end
    nReset = 1'b1;
  endtask

  task automatic settle();
    {nFork, nCrank, nMode, nTrip} = 4'b1111;
    for (int j = 0; j < 2 * BD + 4; j++) begin
      @(negedge Clock);
      tests++;
      if (outVec !== expVec) begin
        fails++;
        $display("FAIL settle_cycle: got %b expected %b", outVec, expVec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sensor_edge();   settle();
    test_short_press();   settle();
    test_long_press();    settle();
    test_both_long();     settle();
    test_both_abort();    settle();
    test_crank_and_reset(); settle();
    test_random();        settle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
